// File: rtl/eth_pcs_rx_block_sync.sv
// 10GBASE-R receive block lock: tests the sync header of every 66-bit block and
// slips the RX gearbox one bit at a time until headers align.

package eth_pcs_params;
  localparam int          SH_TH       = 64;
  localparam int          SH_INVAL_TH = 16;
  localparam int          W_SYNC      = 2;
  localparam logic [1:0]  SYNC_DATA   = 2'b10;
  localparam logic [1:0]  SYNC_CTRL   = 2'b01;
endpackage

module eth_pcs_rx_block_sync #(
  parameter int SH_TH       = eth_pcs_params::SH_TH,
  parameter int SH_INVAL_TH = eth_pcs_params::SH_INVAL_TH,
  parameter int SLIP_WAIT   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_hdr_valid,
  input  logic [eth_pcs_params::W_SYNC-1:0] i_sync,
  output logic                              o_slip,
  output logic                              o_block_lock,
  output logic                              o_sh_err
);

  localparam int W_SH_TH       = (SH_TH > 1) ? $clog2(SH_TH) : 1;
  localparam int W_SH_INVAL_TH = (SH_INVAL_TH > 1) ? $clog2(SH_INVAL_TH) : 1;
  localparam int W_WAIT        = 8;

  localparam logic [W_SH_TH-1:0]       SH_LAST   = W_SH_TH'(SH_TH - 1);
  localparam logic [W_SH_INVAL_TH-1:0] INV_LAST  = W_SH_INVAL_TH'(SH_INVAL_TH - 1);
  localparam logic [W_WAIT-1:0]        WAIT_INIT = W_WAIT'(SLIP_WAIT - 1);

  localparam logic [0:0] TEST_SH = 1'b0;
  localparam logic [0:0] SLIP    = 1'b1;

  logic [0:0]               state;
  logic [W_SH_TH-1:0]       sh_cnt;
  logic [W_SH_INVAL_TH-1:0] inv_cnt;
  logic [W_WAIT-1:0]        wait_cnt;

  logic hdr_ok;
  logic win_end;
  logic inv_full;

  assign hdr_ok   = (i_sync == eth_pcs_params::SYNC_DATA) ||
                    (i_sync == eth_pcs_params::SYNC_CTRL);
  // Counters stop one short of the threshold; the last slot marks the boundary.
  assign win_end  = (sh_cnt == SH_LAST);
  assign inv_full = (inv_cnt == INV_LAST);

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; blocking ones would race against other flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= TEST_SH;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_sh_err     <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the cycle that triggers them.
      o_slip   <= 1'b0;
      o_sh_err <= 1'b0;
      case (state)
        TEST_SH: begin
          if (i_hdr_valid) begin
            if (hdr_ok) begin
              if (win_end) begin
                if (inv_cnt == '0) o_block_lock <= 1'b1;
                sh_cnt  <= '0;
                inv_cnt <= '0;
              end else begin
                sh_cnt <= sh_cnt + W_SH_TH'(1);
              end
            end else begin
              o_sh_err <= 1'b1;
              if (!o_block_lock || inv_full) begin
                state        <= SLIP;
                o_slip       <= 1'b1;
                o_block_lock <= 1'b0;
                sh_cnt       <= '0;
                inv_cnt      <= '0;
                wait_cnt     <= WAIT_INIT;
              end else if (win_end) begin
                sh_cnt  <= '0;
                inv_cnt <= '0;
              end else begin
                sh_cnt  <= sh_cnt + W_SH_TH'(1);
                inv_cnt <= inv_cnt + W_SH_INVAL_TH'(1);
              end
            end
          end
        end
        SLIP: begin
          // Gearbox is realigning: headers seen now belong to no block boundary.
          if (wait_cnt == '0) state <= TEST_SH;
          else                wait_cnt <= wait_cnt - W_WAIT'(1);
        end
        default: state <= TEST_SH;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Self-checking bench for eth_pcs_rx_block_sync: directed scenarios plus a
// randomized stream compared against a window-counting reference model.

module tb_eth_pcs_rx_block_sync;

  localparam int SH_TH       = 64;
  localparam int SH_INVAL_TH = 16;
  localparam int SLIP_WAIT   = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_hdr_valid;
  logic [1:0] i_sync;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_sh_err;

  int n_checks = 0;
  int n_pass   = 0;
  int slip_seen;
  int err_seen;

  // Reference model: header count within the window (1..SH_TH), invalid count,
  // lock flag and number of cycles still blind after a slip.
  bit m_lock;
  int m_hdrs;
  int m_invs;
  int m_blind;
  bit m_slip;
  bit m_err;

  eth_pcs_rx_block_sync #(
    .SH_TH      (SH_TH),
    .SH_INVAL_TH(SH_INVAL_TH),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_hdr_valid (i_hdr_valid),
    .i_sync      (i_sync),
    .o_slip      (o_slip),
    .o_block_lock(o_block_lock),
    .o_sh_err    (o_sh_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_lock  = 1'b0;
    m_hdrs  = 0;
    m_invs  = 0;
    m_blind = 0;
    m_slip  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] s);
    m_slip = 1'b0;
    m_err  = 1'b0;
    if (m_blind > 0) begin
      m_blind--;
    end else if (v) begin
      m_hdrs++;
      if (s == 2'b01 || s == 2'b10) begin
        if (m_hdrs == SH_TH) begin
          if (m_invs == 0) m_lock = 1'b1;
          m_hdrs = 0;
          m_invs = 0;
        end
      end else begin
        m_err = 1'b1;
        m_invs++;
        if (!m_lock || m_invs == SH_INVAL_TH) begin
          m_slip  = 1'b1;
          m_lock  = 1'b0;
          m_hdrs  = 0;
          m_invs  = 0;
          m_blind = SLIP_WAIT;
        end else if (m_hdrs == SH_TH) begin
          m_hdrs = 0;
          m_invs = 0;
        end
      end
    end
  endtask

  function automatic logic [1:0] good_sync();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  // Drive one cycle, advance the model, sample 1 ns after the edge.
  task automatic step(input logic v, input logic [1:0] s);
    i_hdr_valid = v;
    i_sync      = s;
    @(posedge i_clk);
    model_step(v, s);
    #1;
    if (o_slip)   slip_seen++;
    if (o_sh_err) err_seen++;
  endtask

  task automatic apply_reset();
    i_rst       = 1'b1;
    i_hdr_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  // Sends span headers with n_bad invalid ones at random distinct positions,
  // optionally followed by one more invalid header.
  task automatic send_window(input int n_bad, input int span, input bit last_bad,
                             input bit gaps);
    int idx[64];
    bit bad[65];
    for (int i = 0; i < 64; i++) idx[i] = i + 1;
    for (int i = 0; i < 65; i++) bad[i] = 1'b0;
    for (int i = 0; i < n_bad; i++) begin
      int j;
      int t;
      j = int'($urandom_range(span - 1, i));
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
      bad[idx[i]] = 1'b1;
    end
    for (int p = 1; p <= span; p++) begin
      step(1'b1, bad[p] ? 2'b00 : good_sync());
      if (gaps && $urandom_range(0, 1) != 0) step(1'b0, 2'($urandom_range(0, 3)));
    end
    if (last_bad) step(1'b1, 2'b00);
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_hdr_valid = 1'b0;
    i_sync      = 2'b00;
    @(negedge i_clk);
    n_checks++; if (o_block_lock !== 1'b0) $display("FAIL reset_lock: got %b want 0", o_block_lock); else n_pass++;
    n_checks++; if (o_slip !== 1'b0) $display("FAIL reset_slip: got %b want 0", o_slip); else n_pass++;
    n_checks++; if (o_sh_err !== 1'b0) $display("FAIL reset_sh_err: got %b want 0", o_sh_err); else n_pass++;
    i_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00);
    n_checks++; if ({o_block_lock, o_slip, o_sh_err} !== 3'b000) $display("FAIL reset_idle: got %b want 000", {o_block_lock, o_slip, o_sh_err}); else n_pass++;
  endtask

  task automatic test_lock_acquire();
    apply_reset();
    slip_seen = 0;
    err_seen  = 0;
    for (int h = 1; h <= SH_TH; h++) begin
      step(1'b1, good_sync());
      if (h == SH_TH - 1) begin
        n_checks++; if (o_block_lock !== 1'b0) $display("FAIL acquire_lock_63: got %b want 0", o_block_lock); else n_pass++;
      end
      if (h == SH_TH) begin
        n_checks++; if (o_block_lock !== 1'b1) $display("FAIL acquire_lock_64: got %b want 1", o_block_lock); else n_pass++;
      end
      step(1'b0, 2'($urandom_range(0, 3)));
    end
    n_checks++; if (slip_seen != 0) $display("FAIL acquire_no_slip: got %0d slips want 0", slip_seen); else n_pass++;
    n_checks++; if (err_seen != 0) $display("FAIL acquire_no_err: got %0d errs want 0", err_seen); else n_pass++;
  endtask

  task automatic test_slip_unlocked();
    apply_reset();
    slip_seen = 0;
    err_seen  = 0;
    for (int h = 1; h <= 9; h++) step(1'b1, good_sync());
    step(1'b1, 2'b11);
    n_checks++; if (o_slip !== 1'b1) $display("FAIL slip_pulse: got %b want 1", o_slip); else n_pass++;
    n_checks++; if (o_sh_err !== 1'b1) $display("FAIL slip_sh_err: got %b want 1", o_sh_err); else n_pass++;
    for (int k = 0; k < SLIP_WAIT; k++) begin
      step(1'b1, (k % 2 == 0) ? 2'b00 : 2'b11);
      n_checks++; if ({o_slip, o_sh_err} !== 2'b00) $display("FAIL slip_blind_%0d: got slip/err %b want 00", k, {o_slip, o_sh_err}); else n_pass++;
    end
    n_checks++; if (slip_seen != 1 || err_seen != 1) $display("FAIL slip_counts: got %0d slips %0d errs want 1 1", slip_seen, err_seen); else n_pass++;
    for (int h = 1; h <= SH_TH; h++) begin
      step(1'b1, good_sync());
      if (h == SH_TH - 1) begin
        n_checks++; if (o_block_lock !== 1'b0) $display("FAIL relock_63: got %b want 0", o_block_lock); else n_pass++;
      end
    end
    n_checks++; if (o_block_lock !== 1'b1) $display("FAIL relock_64: got %b want 1", o_block_lock); else n_pass++;
  endtask

  task automatic test_locked_tolerance();
    slip_seen = 0;
    err_seen  = 0;
    for (int w = 0; w < 3; w++) begin
      send_window(SH_INVAL_TH - 1, SH_TH, 1'b0, 1'b1);
      n_checks++; if (o_block_lock !== m_lock || o_block_lock !== 1'b1) $display("FAIL tolerate_lock_w%0d: got %b want 1", w, o_block_lock); else n_pass++;
    end
    n_checks++; if (err_seen != 45) $display("FAIL tolerate_err_count: got %0d want 45", err_seen); else n_pass++;
    n_checks++; if (slip_seen != 0) $display("FAIL tolerate_no_slip: got %0d want 0", slip_seen); else n_pass++;
  endtask

  task automatic test_drop_at_40();
    send_window(SH_INVAL_TH - 1, 39, 1'b1, 1'b0);
    n_checks++; if (o_block_lock !== 1'b0) $display("FAIL drop40_lock: got %b want 0", o_block_lock); else n_pass++;
    n_checks++; if (o_slip !== 1'b1) $display("FAIL drop40_slip: got %b want 1", o_slip); else n_pass++;
    for (int k = 0; k < SLIP_WAIT; k++) step(1'b0, 2'b00);
    send_window(0, SH_TH, 1'b0, 1'b0);
    n_checks++; if (o_block_lock !== 1'b1) $display("FAIL drop40_relock: got %b want 1", o_block_lock); else n_pass++;
  endtask

  task automatic test_window_boundary();
    send_window(SH_INVAL_TH - 1, SH_TH - 1, 1'b1, 1'b0);
    n_checks++; if (o_block_lock !== 1'b0) $display("FAIL edge15_lock: got %b want 0", o_block_lock); else n_pass++;
    n_checks++; if (o_slip !== 1'b1) $display("FAIL edge15_slip: got %b want 1", o_slip); else n_pass++;
    for (int k = 0; k < SLIP_WAIT; k++) step(1'b0, 2'b00);
    send_window(0, SH_TH, 1'b0, 1'b0);
    slip_seen = 0;
    send_window(SH_INVAL_TH - 2, SH_TH - 1, 1'b1, 1'b0);
    n_checks++; if (o_block_lock !== 1'b1) $display("FAIL edge14_lock: got %b want 1", o_block_lock); else n_pass++;
    n_checks++; if ({o_slip, o_sh_err} !== 2'b01) $display("FAIL edge14_pulses: got slip/err %b want 01", {o_slip, o_sh_err}); else n_pass++;
    send_window(SH_INVAL_TH - 1, SH_TH, 1'b0, 1'b0);
    n_checks++; if (o_block_lock !== 1'b1 || slip_seen != 0) $display("FAIL edge14_cleared: got lock %b slips %0d want 1 0", o_block_lock, slip_seen); else n_pass++;
  endtask

  task automatic test_async_reset();
    n_checks++; if (o_block_lock !== 1'b1) $display("FAIL areset_prelock: got %b want 1", o_block_lock); else n_pass++;
    #3;
    i_rst = 1'b1;
    #1;
    n_checks++; if (o_block_lock !== 1'b0) $display("FAIL areset_lock_drop: got %b want 0", o_block_lock); else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    step(1'b1, 2'b11);
    n_checks++; if (o_slip !== 1'b1) $display("FAIL areset_slip_pre: got %b want 1", o_slip); else n_pass++;
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++; if ({o_slip, o_block_lock} !== 2'b00) $display("FAIL areset_slip_cut: got slip/lock %b want 00", {o_slip, o_block_lock}); else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    for (int h = 1; h <= SH_TH; h++) begin
      step(1'b1, good_sync());
      if (h == SH_TH - 1) begin
        n_checks++; if (o_block_lock !== 1'b0) $display("FAIL areset_relock_63: got %b want 0", o_block_lock); else n_pass++;
      end
    end
    n_checks++; if (o_block_lock !== 1'b1) $display("FAIL areset_relock_64: got %b want 1", o_block_lock); else n_pass++;
  endtask

  task automatic test_random();
    int rates[5] = '{0, 300, 8, 4, 40};
    logic       v;
    logic [1:0] s;
    apply_reset();
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < 800; c++) begin
        v = ($urandom_range(0, 3) != 0);
        if (rates[ph] != 0 && $urandom_range(0, rates[ph] - 1) == 0)
          s = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        else
          s = good_sync();
        step(v, s);
        n_checks++; if (o_block_lock !== m_lock) $display("FAIL rand_lock p%0d c%0d: got %b want %b", ph, c, o_block_lock, m_lock); else n_pass++;
        n_checks++; if (o_slip !== m_slip) $display("FAIL rand_slip p%0d c%0d: got %b want %b", ph, c, o_slip, m_slip); else n_pass++;
        n_checks++; if (o_sh_err !== m_err) $display("FAIL rand_sh_err p%0d c%0d: got %b want %b", ph, c, o_sh_err, m_err); else n_pass++;
      end
    end
  endtask

  initial begin
    slip_seen = 0;
    err_seen  = 0;
    model_reset();
    test_reset();
    test_lock_acquire();
    test_slip_unlocked();
    test_locked_tolerance();
    test_drop_at_40();
    test_window_boundary();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_sync.md
Name: eth_pcs_rx_block_sync

Overview:
- RX block-lock state machine for the 10GBASE-R PCS (IEEE 802.3 cl.49.2.13 semantics).
- Sits between the RX gearbox and the descrambler/decoder. It tests the 2-bit sync header of each received 66-bit block.
- Commands the RX gearbox to slip one bit position until headers align, then reports block lock.
- Uses SH_TH / SH_INVAL_TH and SYNC_DATA / SYNC_CTRL from eth_pcs_params.

Parameters:
- SH_TH, default 64 (eth_pcs_params::SH_TH): headers per test window.
- SH_INVAL_TH, default 16 (eth_pcs_params::SH_INVAL_TH): invalid headers per window that cause loss of lock.
- SLIP_WAIT, default 4: cycles after a slip during which headers are ignored while the gearbox realigns. Legal range 1..255.

Ports:
- i_clk  in  1  PCS RX clock
- i_rst  in  1  asynchronous, active-high reset
- i_hdr_valid  in  1  i_sync carries the header of a new block this cycle
- i_sync  in  W_SYNC(2)  sync header in transmission order, from RX gearbox
- o_slip  out  1  one-cycle pulse: gearbox shifts block boundary by one bit
- o_block_lock  out  1  block lock achieved
- o_sh_err  out  1  one-cycle pulse, registered: an invalid header was tested

Behaviour:
- Clock and reset: one clock (i_clk). i_rst is asynchronous, active-high.
- Reset values: o_slip=0, o_block_lock=0, o_sh_err=0, state=TEST_SH, sh_cnt=0, inv_cnt=0, wait_cnt=0.
- Header validity: the header is valid iff i_sync==SYNC_DATA (2'b10) or i_sync==SYNC_CTRL (2'b01). 2'b00 and 2'b11 are invalid.
- Counter ranges:
  - sh_cnt is W_SH_TH bits and holds 0..SH_TH-1. Test sh_cnt==SH_TH-1 as "window complete"; never count to SH_TH.
  - inv_cnt is W_SH_INVAL_TH bits and holds 0..SH_INVAL_TH-1, with the same rule.
- FSM states: TEST_SH, SLIP.
- TEST_SH, i_hdr_valid=0: no change.
- TEST_SH, i_hdr_valid=1, valid header:
  - If sh_cnt==SH_TH-1: end of window. If inv_cnt==0, set o_block_lock=1. Clear sh_cnt and inv_cnt.
  - Otherwise: sh_cnt+1.
- TEST_SH, i_hdr_valid=1, invalid header: o_sh_err=1 on the next cycle. Then:
  - o_block_lock=0: go to SLIP.
  - o_block_lock=1 and inv_cnt==SH_INVAL_TH-1: go to SLIP and clear o_block_lock.
  - Otherwise, if sh_cnt==SH_TH-1: window ends. Clear both counters; lock stays 1 (the window had fewer than SH_INVAL_TH errors).
  - Otherwise: sh_cnt+1 and inv_cnt+1.
- Entering SLIP (registered, so these appear the cycle after the triggering header):
  - o_slip=1 for exactly one cycle.
  - o_block_lock=0; sh_cnt, inv_cnt cleared; wait_cnt=SLIP_WAIT-1.
- In SLIP:
  - i_hdr_valid and i_sync are ignored; wait_cnt decrements.
  - At wait_cnt==0, go to TEST_SH the next cycle.
  - o_slip is never asserted twice within SLIP_WAIT+1 cycles.
- Latency: o_block_lock rises one cycle after the i_hdr_valid cycle carrying the SH_TH-th consecutive valid header.
- Lock persistence: once locked, a window with 0..SH_INVAL_TH-1 invalid headers keeps lock. The SH_INVAL_TH-th invalid header in one window drops lock immediately, without waiting for the window end.
- Reset mid-operation:
  - All state returns to reset values asynchronously; any in-flight o_slip pulse is cut.
  - The first header after deassertion starts a fresh window.
- o_sh_err is also asserted for invalid headers that trigger SLIP. No o_sh_err while in SLIP.

Test Plan:
- From reset, 64 headers of 2'b01/2'b10 with i_hdr_valid every second cycle -> o_block_lock=0 after the 63rd header, 1 the cycle after the 64th; o_slip never asserts.
- Unlocked, header #10 = 2'b11:
  - o_slip pulses exactly one cycle; o_sh_err pulses once.
  - With SLIP_WAIT=4, headers in the following 4 cycles are ignored, including invalid ones (no second slip).
  - Lock then needs 64 fresh valid headers.
- Locked, 15 invalid headers (2'b00) spread over a 64-header window, repeated for 3 windows -> o_block_lock stays 1, no o_slip, 45 o_sh_err pulses.
- Locked, 16th invalid header at position 40 of a window -> o_block_lock=0 and o_slip=1 on the next cycle.
- Window boundary: locked, invalid header exactly at header 64 with inv_cnt=15 -> lock lost, not window reset. The same case with inv_cnt=14 -> counters clear, lock held.
- i_rst asserted asynchronously between clock edges while locked and while in SLIP -> o_block_lock and o_slip drop immediately. After release, the next 64 valid headers relock.
